// File: rtl/decode_pkg.sv
// Shared opcode, branch-condition and ID/EX control definitions for the
// 16-bit ISA decode stage.
package decode_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;
  localparam logic [2:0] COND_AL = 3'b111;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic       reg_wr;
    logic       mem_wr;
    logic       mem_rd;
    logic       mem_to_reg;
    logic       halt;
  } id_ex_ctrl_t;

  function automatic logic is_flag_setter(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR);
  endfunction

  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
    logic z, v, n;
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    n = flags[FLAG_N];
    case (cond)
      COND_NE: return !z;
      COND_EQ: return z;
      COND_GT: return !z && !n;
      COND_LT: return n;
      COND_GE: return z || !n;
      COND_LE: return n || z;
      COND_OV: return v;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/decode_hazard_unit_reg_file_bypass.sv
// Two-read/one-write register file with optional hard-wired zero register
// and same-cycle write-back forwarding onto the read ports.
module reg_file_bypass #(
  parameter int NREGS    = 16,
  parameter int DATA_W   = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [AW-1:0]     raddr [2];
  logic [DATA_W-1:0] rdata [2];

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
    // Register 0 is never written when it is the zero register.
    localparam bit WRITABLE = !((ZERO_REG != 0) && (gi == 0));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs[gi] <= '0;
      end else if (WRITABLE && we && (waddr == AW'(gi))) begin
        regs[gi] <= wdata;
      end
    end
  end

  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  assign rdata1   = rdata[0];
  assign rdata2   = rdata[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    always_comb begin
      rdata[gi] = regs[raddr[gi]];
      if ((BYPASS != 0) && we && (waddr == raddr[gi])) begin
        rdata[gi] = wdata;
      end
      if ((ZERO_REG != 0) && (raddr[gi] == '0)) begin
        rdata[gi] = '0;
      end
    end
  end

endmodule

// File: rtl/decode_hazard_unit.sv
// Decode stage: field/control decode, operand read, branch resolution,
// load-use / branch-register / flag hazard detection and the ID/EX register.
module decode_hazard_unit
  import decode_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NREGS    = 16,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int REG_AW  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic [DATA_W-1:0] if_pc_next,
  input  logic [2:0]        flags,
  input  logic              ex_stall,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              id_flush,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic              ex_valid,
  output logic [3:0]        ex_opcode,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_data1,
  output logic [DATA_W-1:0] ex_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_wr,
  output logic              ex_mem_wr,
  output logic              ex_mem_rd,
  output logic              ex_mem_to_reg,
  output logic              ex_halt,
  output logic              halted
);

  logic [3:0]        opcode;
  logic [2:0]        cond;
  logic [REG_AW-1:0] f_rd, f_rs, f_rt;
  logic [REG_AW-1:0] rs, rt;
  logic              use_rs, use_rt;
  logic              is_b, is_br, is_branch, taken;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] b_target;
  logic              hz_load, hz_breg, hz_flag, hazard, normal;
  id_ex_ctrl_t       ctrl_next;
  id_ex_ctrl_t       ex_ctrl_reg;
  logic              halted_reg;

  assign opcode = if_instr[15:12];
  assign cond   = if_instr[11:9];
  assign f_rd   = if_instr[8 +: REG_AW];
  assign f_rs   = if_instr[4 +: REG_AW];
  assign f_rt   = if_instr[0 +: REG_AW];

  // SW carries its store-data register in the rd slot; LLB/LHB modify rd in place.
  assign rs = ((opcode == OP_LLB) || (opcode == OP_LHB)) ? f_rd : f_rs;
  assign rt = (opcode == OP_SW) ? f_rd : f_rt;

  assign use_rs = !((opcode == OP_B) || (opcode == OP_PCS) || (opcode == OP_HLT));
  // Shifts take their amount from the rt slot as an immediate, so only these read rt.
  assign use_rt = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_XOR) ||
                  (opcode == OP_RED) || (opcode == OP_PADDSB) || (opcode == OP_SW);

  assign is_b      = (opcode == OP_B);
  assign is_br     = (opcode == OP_BR);
  assign is_branch = is_b || is_br;
  assign taken     = if_valid && is_branch && cond_true(cond, flags);

  reg_file_bypass #(
    .NREGS    (NREGS),
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .waddr  (wb_reg),
    .wdata  (wb_data)
  );

  always_comb begin
    imm = '0;
    if ((opcode == OP_LLB) || (opcode == OP_LHB)) begin
      imm = {{(DATA_W-8){if_instr[7]}}, if_instr[7:0]};
    end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
      imm = {{(DATA_W-5){if_instr[3]}}, if_instr[3:0], 1'b0};
    end
  end

  assign b_target  = if_pc_next + {{(DATA_W-10){if_instr[8]}}, if_instr[8:0], 1'b0};
  assign pc_target = is_br ? rdata1 : b_target;

  function automatic logic reg_hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a == b) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    hz_load = ex_ctrl_reg.mem_rd &&
              ((use_rs && reg_hit(ex_rd, rs)) || (use_rt && reg_hit(ex_rd, rt)));
    hz_breg = is_br && ex_ctrl_reg.reg_wr && reg_hit(ex_rd, rs);
    hz_flag = is_branch && (cond != COND_AL) && is_flag_setter(ex_ctrl_reg.opcode);
    hazard  = if_valid && ex_ctrl_reg.valid && (hz_load || hz_breg || hz_flag);
  end

  assign normal      = !halted_reg && !ex_stall && !hazard;
  assign id_stall    = halted_reg || ex_stall || hazard;
  assign pc_redirect = taken && normal;
  assign id_flush    = pc_redirect;

  always_comb begin
    ctrl_next            = '0;
    ctrl_next.valid      = if_valid;
    ctrl_next.opcode     = opcode;
    ctrl_next.reg_wr     = if_valid && !((opcode == OP_SW) || is_branch || (opcode == OP_HLT));
    ctrl_next.mem_wr     = if_valid && (opcode == OP_SW);
    ctrl_next.mem_rd     = if_valid && (opcode == OP_LW);
    ctrl_next.mem_to_reg = (opcode != OP_LW);
    ctrl_next.halt       = if_valid && (opcode == OP_HLT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_reg <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_data1    <= '0;
      ex_data2    <= '0;
      ex_imm      <= '0;
      halted_reg  <= 1'b0;
    end else begin
      if (halted_reg || (!ex_stall && hazard)) begin
        ex_ctrl_reg <= '0;
      end else if (!ex_stall) begin
        ex_ctrl_reg <= ctrl_next;
        ex_rs       <= rs;
        ex_rt       <= rt;
        ex_rd       <= f_rd;
        ex_data1    <= rdata1;
        ex_data2    <= rdata2;
        ex_imm      <= imm;
      end
      if (normal && ctrl_next.halt) begin
        halted_reg <= 1'b1;
      end
    end
  end

  assign ex_valid      = ex_ctrl_reg.valid;
  assign ex_opcode     = ex_ctrl_reg.opcode;
  assign ex_reg_wr     = ex_ctrl_reg.reg_wr;
  assign ex_mem_wr     = ex_ctrl_reg.mem_wr;
  assign ex_mem_rd     = ex_ctrl_reg.mem_rd;
  assign ex_mem_to_reg = ex_ctrl_reg.mem_to_reg;
  assign ex_halt       = ex_ctrl_reg.halt;
  assign halted        = halted_reg;

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed, table-driven bench for decode_hazard_unit: one vector per cycle,
// plus a hand-written reset-during-halt sequence.
module tb_decode_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc_next;
  logic [2:0]  flags;
  logic        ex_stall;
  logic        wb_en;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        id_stall, id_flush, pc_redirect;
  logic [15:0] pc_target;
  logic        ex_valid;
  logic [3:0]  ex_opcode, ex_rs, ex_rt, ex_rd;
  logic [15:0] ex_data1, ex_data2, ex_imm;
  logic        ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_mem_to_reg, ex_halt, halted;

  int checks = 0;
  int errors = 0;

  decode_hazard_unit dut (
    .clk (clk), .rst_n (rst_n),
    .if_valid (if_valid), .if_instr (if_instr), .if_pc_next (if_pc_next),
    .flags (flags), .ex_stall (ex_stall),
    .wb_en (wb_en), .wb_reg (wb_reg), .wb_data (wb_data),
    .id_stall (id_stall), .id_flush (id_flush),
    .pc_redirect (pc_redirect), .pc_target (pc_target),
    .ex_valid (ex_valid), .ex_opcode (ex_opcode),
    .ex_rs (ex_rs), .ex_rt (ex_rt), .ex_rd (ex_rd),
    .ex_data1 (ex_data1), .ex_data2 (ex_data2), .ex_imm (ex_imm),
    .ex_reg_wr (ex_reg_wr), .ex_mem_wr (ex_mem_wr), .ex_mem_rd (ex_mem_rd),
    .ex_mem_to_reg (ex_mem_to_reg), .ex_halt (ex_halt), .halted (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        iv;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  fl;
    logic        xs;
    logic        wbe;
    logic [3:0]  wbr;
    logic [15:0] wbd;
    logic        e_stall;
    logic        e_flush;
    logic        chk_tgt;
    logic [15:0] e_tgt;
    logic        e_valid;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic [3:0]  e_rs;
    logic [3:0]  e_rt;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic [15:0] e_imm;
    logic [4:0]  e_ctl;
    logic        e_halted;
  } vec_t;

  // {reg_wr, mem_wr, mem_rd, mem_to_reg, halt}
  localparam logic [4:0] C_ALU  = 5'b10010;
  localparam logic [4:0] C_LW   = 5'b10100;
  localparam logic [4:0] C_BR   = 5'b00010;
  localparam logic [4:0] C_HLT  = 5'b00011;
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam int NV = 25;

  vec_t vecs [NV];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    check("rst_ctrl", idx, {22'd0, ex_valid, ex_opcode, ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_mem_to_reg, ex_halt}, 32'd0);
    check("rst_regs", idx, {20'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    check("rst_d1", idx, {16'd0, ex_data1}, 32'd0);
    check("rst_d2", idx, {16'd0, ex_data2}, 32'd0);
    check("rst_imm", idx, {16'd0, ex_imm}, 32'd0);
    check("rst_halted", idx, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    // iv instr pc flags xs wbe wbr wbd | stall flush chk tgt | valid op rd rs rt d1 d2 imm ctl halted
    vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 4'd2, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[2]  = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 4'd3, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 3'b000, 1'b0, 1'b1, 4'd5, 16'h0505, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    // ADD R1,R2,R3 then dependent SUB R4,R1,R5: no stall
    vecs[4]  = '{1'b1, 16'h0123, 16'h0002, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0000, C_ALU, 1'b0};
    vecs[5]  = '{1'b1, 16'h1415, 16'h0004, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'd4, 4'd1, 4'd5, 16'h0000, 16'h0505, 16'h0000, C_ALU, 1'b0};
    // LW R1,[R2+6] then ADD R2,R1,R3: one bubble
    vecs[6]  = '{1'b1, 16'h8123, 16'h0006, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h8, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0006, C_LW, 1'b0};
    vecs[7]  = '{1'b1, 16'h0213, 16'h0008, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[8]  = '{1'b1, 16'h0213, 16'h0008, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'd2, 4'd1, 4'd3, 16'h0000, 16'h2222, 16'h0000, C_ALU, 1'b0};
    // SUB then B EQ +4 with Z=1: bubble, then redirect to 0x0018
    vecs[9]  = '{1'b1, 16'h1415, 16'h000A, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h1, 4'd4, 4'd1, 4'd5, 16'h0000, 16'h0505, 16'h0000, C_ALU, 1'b0};
    vecs[10] = '{1'b1, 16'hC204, 16'h0010, 3'b100, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0018, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[11] = '{1'b1, 16'hC204, 16'h0010, 3'b100, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0018, 1'b1, 4'hC, 4'd2, 4'd0, 4'd4, 16'h0000, 16'h0000, 16'h0000, C_BR, 1'b0};
    // same branch, Z=0: not taken, no flag hazard behind another branch
    vecs[12] = '{1'b1, 16'hC204, 16'h0010, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0018, 1'b1, 4'hC, 4'd2, 4'd0, 4'd4, 16'h0000, 16'h0000, 16'h0000, C_BR, 1'b0};
    // BR R5 (always) with same-cycle write-back R5=0xBEEF
    vecs[13] = '{1'b1, 16'hDE50, 16'h0012, 3'b000, 1'b0, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 4'hD, 4'd14, 4'd5, 4'd0, 16'hBEEF, 16'h0000, 16'h0000, C_BR, 1'b0};
    // LW, then ex_stall x3 with dependent ADD waiting, then hazard bubble, then issue
    vecs[14] = '{1'b1, 16'h8123, 16'h0020, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h8, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0006, C_LW, 1'b0};
    vecs[15] = '{1'b1, 16'h0213, 16'h0022, 3'b000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h8, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0006, C_LW, 1'b0};
    vecs[16] = '{1'b1, 16'h0213, 16'h0022, 3'b000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h8, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0006, C_LW, 1'b0};
    vecs[17] = '{1'b1, 16'h0213, 16'h0022, 3'b000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h8, 4'd1, 4'd2, 4'd3, 16'h1111, 16'h2222, 16'h0006, C_LW, 1'b0};
    vecs[18] = '{1'b1, 16'h0213, 16'h0022, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[19] = '{1'b1, 16'h0213, 16'h0022, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 4'd2, 4'd1, 4'd3, 16'h0000, 16'h2222, 16'h0000, C_ALU, 1'b0};
    // BR R2 right behind ADD writing R2: branch-register bubble, then redirect
    vecs[20] = '{1'b1, 16'hDE20, 16'h0024, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b0};
    vecs[21] = '{1'b1, 16'hDE20, 16'h0024, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h1111, 1'b1, 4'hD, 4'd14, 4'd2, 4'd0, 16'h1111, 16'h0000, 16'h0000, C_BR, 1'b0};
    // HLT, then everything stalls with bubbles
    vecs[22] = '{1'b1, 16'hF000, 16'h1112, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 4'hF, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_HLT, 1'b1};
    vecs[23] = '{1'b1, 16'h0123, 16'h1114, 3'b000, 1'b0, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b1};
    vecs[24] = '{1'b1, 16'h0123, 16'h1114, 3'b000, 1'b1, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, C_NONE, 1'b1};

    rst_n = 1'b0;
    if_valid = 1'b0; if_instr = '0; if_pc_next = '0; flags = '0;
    ex_stall = 1'b0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(-1);
    check("rst_id_stall", -1, {31'd0, id_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      if_valid = vecs[i].iv; if_instr = vecs[i].instr; if_pc_next = vecs[i].pc;
      flags = vecs[i].fl; ex_stall = vecs[i].xs;
      wb_en = vecs[i].wbe; wb_reg = vecs[i].wbr; wb_data = vecs[i].wbd;
      #1;
      check("id_stall", i, {31'd0, id_stall}, {31'd0, vecs[i].e_stall});
      check("id_flush", i, {31'd0, id_flush}, {31'd0, vecs[i].e_flush});
      check("pc_redirect", i, {31'd0, pc_redirect}, {31'd0, vecs[i].e_flush});
      if (vecs[i].chk_tgt) check("pc_target", i, {16'd0, pc_target}, {16'd0, vecs[i].e_tgt});
      @(posedge clk);
      #1;
      $display("step %0d instr=%h id_stall=%b id_flush=%b ex_valid=%b ex_opcode=%h halted=%b",
               i, vecs[i].instr, vecs[i].e_stall, vecs[i].e_flush, ex_valid, ex_opcode, halted);
      check("ex_valid", i, {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      check("halted", i, {31'd0, halted}, {31'd0, vecs[i].e_halted});
      if (vecs[i].e_valid) begin
        check("ex_ctl", i, {27'd0, ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_mem_to_reg, ex_halt}, {27'd0, vecs[i].e_ctl});
        check("ex_opcode", i, {28'd0, ex_opcode}, {28'd0, vecs[i].e_op});
        check("ex_regs", i, {20'd0, ex_rd, ex_rs, ex_rt}, {20'd0, vecs[i].e_rd, vecs[i].e_rs, vecs[i].e_rt});
        check("ex_data1", i, {16'd0, ex_data1}, {16'd0, vecs[i].e_d1});
        check("ex_data2", i, {16'd0, ex_data2}, {16'd0, vecs[i].e_d2});
        check("ex_imm", i, {16'd0, ex_imm}, {16'd0, vecs[i].e_imm});
      end else begin
        check("bubble_en", i, {28'd0, ex_reg_wr, ex_mem_wr, ex_mem_rd, ex_halt}, 32'd0);
      end
    end

    // Reset asserted asynchronously while halted, between clock edges.
    ex_stall = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state(100);
    check("rst_mid_id_stall", 100, {31'd0, id_stall}, 32'd0);
    $display("step 100 async reset while halted: halted=%b ex_valid=%b", halted, ex_valid);

    // After release, ADD R1,R2,R3 issues and R2 reads back as cleared.
    @(negedge clk);
    rst_n = 1'b1;
    if_valid = 1'b1; if_instr = 16'h0123; wb_en = 1'b0;
    #1;
    check("post_rst_id_stall", 101, {31'd0, id_stall}, 32'd0);
    @(posedge clk);
    #1;
    $display("step 101 ADD after reset: ex_valid=%b ex_rd=%0d ex_data1=%h", ex_valid, ex_rd, ex_data1);
    check("post_rst_valid", 101, {31'd0, ex_valid}, 32'd1);
    check("post_rst_rd", 101, {28'd0, ex_rd}, 32'd1);
    check("post_rst_data1", 101, {16'd0, ex_data1}, 32'd0);
    check("post_rst_data2", 101, {16'd0, ex_data2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
